// File: rtl/ctrl_loop_seq.sv
// Loop sequencer: walks k -> ifm -> tile -> ofm nested counters over a valid/ready step interface.
// Optional stall counter output enabled by defining CTRL_LOOP_SEQ_STALLCNT_EN.
module ctrl_loop_seq #(
  parameter int CLOG2W = 6,
  parameter int CLOG2K = 3,
  parameter int CLOG2T = 4,
  parameter int CLOG2B = 6,
  parameter int CLOG2C = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CLOG2W-1:0] arv_npu,
  input  logic [CLOG2K-1:0] arv_ksize,
  input  logic [CLOG2W-1:0] arv_ckgate,
  input  logic [CLOG2T-1:0] arv_tile,
  input  logic [CLOG2B-1:0] arv_ifmaps,
  input  logic [CLOG2C-1:0] arv_ofmaps,
  output logic              step_valid,
  input  logic              step_ready,
  output logic [CLOG2K-1:0] cnt_k,
  output logic [CLOG2B-1:0] cnt_ifm,
  output logic [CLOG2T-1:0] cnt_tile,
  output logic [CLOG2C-1:0] cnt_ofm,
  output logic              first_acc,
  output logic              last_acc,
  output logic [CLOG2W-1:0] cfg_npu,
  output logic [CLOG2W-1:0] cfg_ckgate,
  output logic              busy,
`ifdef CTRL_LOOP_SEQ_STALLCNT_EN
  output logic [15:0]       stall_cnt,
`endif
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t state_reg, state_next;

  logic [CLOG2W-1:0] npu_reg, ckgate_reg;
  logic [CLOG2K-1:0] ksize_reg;
  logic [CLOG2T-1:0] tile_max_reg;
  logic [CLOG2B-1:0] ifmaps_reg;
  logic [CLOG2C-1:0] ofmaps_reg;

  logic [CLOG2K-1:0] k_reg, k_next;
  logic [CLOG2B-1:0] ifm_reg, ifm_next;
  logic [CLOG2T-1:0] tile_reg, tile_next;
  logic [CLOG2C-1:0] ofm_reg, ofm_next;

  logic fire;
  logic wrap_k, wrap_ifm, wrap_tile, wrap_ofm;

  assign fire      = (state_reg == S_RUN) && step_ready;
  assign wrap_k    = (k_reg == ksize_reg);
  assign wrap_ifm  = (ifm_reg == ifmaps_reg);
  assign wrap_tile = (tile_reg == tile_max_reg);
  assign wrap_ofm  = (ofm_reg == ofmaps_reg);

  always_comb begin
    state_next = state_reg;
    k_next     = k_reg;
    ifm_next   = ifm_reg;
    tile_next  = tile_reg;
    ofm_next   = ofm_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) state_next = S_LOAD;
      end
      S_LOAD: begin
        k_next     = '0;
        ifm_next   = '0;
        tile_next  = '0;
        ofm_next   = '0;
        state_next = S_RUN;
      end
      S_RUN: begin
        if (fire) begin
          if (wrap_k && wrap_ifm && wrap_tile && wrap_ofm) begin
            k_next     = '0;
            ifm_next   = '0;
            tile_next  = '0;
            ofm_next   = '0;
            state_next = S_DONE;
          end else begin
            // Ripple carry: each counter moves only when all inner ones wrap.
            k_next = wrap_k ? '0 : k_reg + CLOG2K'(1);
            if (wrap_k)
              ifm_next = wrap_ifm ? '0 : ifm_reg + CLOG2B'(1);
            if (wrap_k && wrap_ifm)
              tile_next = wrap_tile ? '0 : tile_reg + CLOG2T'(1);
            if (wrap_k && wrap_ifm && wrap_tile)
              ofm_next = ofm_reg + CLOG2C'(1);
          end
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      k_reg     <= '0;
      ifm_reg   <= '0;
      tile_reg  <= '0;
      ofm_reg   <= '0;
    end else begin
      state_reg <= state_next;
      k_reg     <= k_next;
      ifm_reg   <= ifm_next;
      tile_reg  <= tile_next;
      ofm_reg   <= ofm_next;
    end
  end

  // Arrival values are captured once per layer so upstream config switches cannot disturb a run.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      npu_reg      <= '0;
      ckgate_reg   <= '0;
      ksize_reg    <= '0;
      tile_max_reg <= '0;
      ifmaps_reg   <= '0;
      ofmaps_reg   <= '0;
    end else if (state_reg == S_LOAD) begin
      npu_reg      <= arv_npu;
      ckgate_reg   <= arv_ckgate;
      ksize_reg    <= arv_ksize;
      tile_max_reg <= arv_tile;
      ifmaps_reg   <= arv_ifmaps;
      ofmaps_reg   <= arv_ofmaps;
    end
  end

`ifdef CTRL_LOOP_SEQ_STALLCNT_EN
  logic [15:0] stall_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_reg <= '0;
    end else if (state_reg == S_LOAD) begin
      stall_reg <= '0;
    end else if ((state_reg == S_RUN) && !step_ready && (stall_reg != 16'hFFFF)) begin
      stall_reg <= stall_reg + 16'd1;
    end
  end

  assign stall_cnt = stall_reg;
`endif

  assign step_valid = (state_reg == S_RUN);
  assign busy       = (state_reg == S_LOAD) || (state_reg == S_RUN);
  assign done       = (state_reg == S_DONE);
  assign cnt_k      = k_reg;
  assign cnt_ifm    = ifm_reg;
  assign cnt_tile   = tile_reg;
  assign cnt_ofm    = ofm_reg;
  assign cfg_npu    = npu_reg;
  assign cfg_ckgate = ckgate_reg;
  assign first_acc  = step_valid && (ifm_reg == '0) && (k_reg == '0);
  assign last_acc   = step_valid && wrap_ifm && wrap_k;

endmodule

// File: tb/tb_ctrl_loop_seq.sv
// Directed bench for ctrl_loop_seq: table of expected steps plus generated nested-loop sequences.
// Covers CTRL_LOOP_SEQ_STALLCNT_EN when that macro is defined.
module tb_ctrl_loop_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [5:0] arv_npu, arv_ckgate, arv_ifmaps, arv_ofmaps;
  logic [2:0] arv_ksize;
  logic [3:0] arv_tile;
  logic       step_valid, step_ready;
  logic [2:0] cnt_k;
  logic [5:0] cnt_ifm, cnt_ofm;
  logic [3:0] cnt_tile;
  logic       first_acc, last_acc;
  logic [5:0] cfg_npu, cfg_ckgate;
  logic       busy, done;
`ifdef CTRL_LOOP_SEQ_STALLCNT_EN
  logic [15:0] stall_cnt;
`endif

  ctrl_loop_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .arv_npu(arv_npu), .arv_ksize(arv_ksize), .arv_ckgate(arv_ckgate),
    .arv_tile(arv_tile), .arv_ifmaps(arv_ifmaps), .arv_ofmaps(arv_ofmaps),
    .step_valid(step_valid), .step_ready(step_ready),
    .cnt_k(cnt_k), .cnt_ifm(cnt_ifm), .cnt_tile(cnt_tile), .cnt_ofm(cnt_ofm),
    .first_acc(first_acc), .last_acc(last_acc),
    .cfg_npu(cfg_npu), .cfg_ckgate(cfg_ckgate), .busy(busy),
`ifdef CTRL_LOOP_SEQ_STALLCNT_EN
    .stall_cnt(stall_cnt),
`endif
    .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] k;
    logic [5:0] ifm;
    logic [3:0] tile;
    logic [5:0] ofm;
    logic       first;
    logic       last;
  } step_t;

  step_t tbl[12];
  step_t exp_q[$];
  int    errors = 0;
  int    checks = 0;

  function automatic step_t mk(int k, int i, int t, int o, int f, int l);
    step_t s;
    s.k = 3'(k); s.ifm = 6'(i); s.tile = 4'(t); s.ofm = 6'(o);
    s.first = 1'(f); s.last = 1'(l);
    return s;
  endfunction

  // {valid, busy, done, first, last, k, ifm, tile, ofm, npu, ckgate}
  function automatic logic [35:0] pk(logic v, logic b, logic d, step_t s, logic [5:0] n, logic [5:0] c);
    return {v, b, d, s.first, s.last, s.k, s.ifm, s.tile, s.ofm, n, c};
  endfunction

  function automatic logic [35:0] obs();
    return {step_valid, busy, done, first_acc, last_acc, cnt_k, cnt_ifm, cnt_tile, cnt_ofm,
            cfg_npu, cfg_ckgate};
  endfunction

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic build_q(input int ks, input int ifm, input int tl, input int ofm);
    exp_q.delete();
    for (int o = 0; o <= ofm; o++)
      for (int t = 0; t <= tl; t++)
        for (int i = 0; i <= ifm; i++)
          for (int k = 0; k <= ks; k++)
            exp_q.push_back(mk(k, i, t, o, (i == 0 && k == 0), (i == ifm && k == ks)));
  endtask

  // Runs one layer against exp_q. mode 1 drives step_ready with the pattern 1,0,0,1.
  task automatic run_layer(input string tag, input int ks, input int ifm, input int tl, input int ofm,
                           input logic [5:0] npu, input logic [5:0] ck,
                           input int mode, input bit change_mid, input bit pulse_start);
    int idx, cyc, stalls;
    logic rdy;
    logic [3:0] pat;
    pat = 4'b1001;
    arv_npu = npu; arv_ckgate = ck; arv_ksize = 3'(ks);
    arv_ifmaps = 6'(ifm); arv_tile = 4'(tl); arv_ofmaps = 6'(ofm);
    start = 1'b1; step_ready = 1'b0;
    tick();
    start = 1'b0;
    check({tag, "_load"}, 36'(obs() >> 33), 36'(3'b010));
    tick();
    idx = 0; cyc = 0; stalls = 0;
    while (idx < exp_q.size()) begin
      if (change_mid && cyc == 1) begin
        arv_npu = ~npu; arv_ckgate = ~ck; arv_ksize = 3'(ks + 1);
        arv_ifmaps = 6'(ifm + 2); arv_tile = 4'(tl + 1); arv_ofmaps = 6'(ofm + 3);
      end
      start = pulse_start && (cyc == 2);
      rdy = (mode == 0) ? 1'b1 : pat[3 - (cyc % 4)];
      step_ready = rdy;
      check({tag, "_step"}, obs(), pk(1'b1, 1'b1, 1'b0, exp_q[idx], npu, ck));
      if (rdy) idx++;
      else stalls++;
      cyc++;
      tick();
    end
    step_ready = 1'b0;
    start = 1'b0;
    check({tag, "_done"}, obs(), pk(1'b0, 1'b0, 1'b1, mk(0, 0, 0, 0, 0, 0), npu, ck));
    tick();
    check({tag, "_idle"}, obs(), pk(1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0), npu, ck));
`ifdef CTRL_LOOP_SEQ_STALLCNT_EN
    check({tag, "_stallcnt"}, 36'(stall_cnt), 36'(stalls));
`endif
  endtask

  initial begin
    tbl[0]  = mk(0, 0, 0, 0, 1, 0);
    tbl[1]  = mk(1, 0, 0, 0, 0, 0);
    tbl[2]  = mk(2, 0, 0, 0, 0, 0);
    tbl[3]  = mk(0, 1, 0, 0, 0, 0);
    tbl[4]  = mk(1, 1, 0, 0, 0, 0);
    tbl[5]  = mk(2, 1, 0, 0, 0, 1);
    tbl[6]  = mk(0, 0, 0, 1, 1, 0);
    tbl[7]  = mk(1, 0, 0, 1, 0, 0);
    tbl[8]  = mk(2, 0, 0, 1, 0, 0);
    tbl[9]  = mk(0, 1, 0, 1, 0, 0);
    tbl[10] = mk(1, 1, 0, 1, 0, 0);
    tbl[11] = mk(2, 1, 0, 1, 0, 1);

    rst_n = 1'b0; start = 1'b0; step_ready = 1'b0;
    arv_npu = 6'd0; arv_ckgate = 6'd0; arv_ksize = 3'd0;
    arv_tile = 4'd0; arv_ifmaps = 6'd0; arv_ofmaps = 6'd0;
    tick();
    tick();
    check("reset", obs(), 36'd0);
    rst_n = 1'b1;
    tick();

    // Reference layer driven from the hand-written table.
    exp_q.delete();
    foreach (tbl[i]) exp_q.push_back(tbl[i]);
    run_layer("basic", 2, 1, 0, 1, 6'd37, 6'd20, 0, 1'b0, 1'b0);

    build_q(0, 0, 0, 0);
    run_layer("single", 0, 0, 0, 0, 6'd63, 6'd1, 0, 1'b0, 1'b0);

    exp_q.delete();
    foreach (tbl[i]) exp_q.push_back(tbl[i]);
    run_layer("stall", 2, 1, 0, 1, 6'd12, 6'd5, 1, 1'b0, 1'b0);

    build_q(2, 1, 0, 1);
    run_layer("cfgswap", 2, 1, 0, 1, 6'd40, 6'd33, 1, 1'b1, 1'b1);

    // Reset while step 5 is presented: layer abandoned, no done pulse afterwards.
    arv_npu = 6'd9; arv_ckgate = 6'd3; arv_ksize = 3'd2;
    arv_ifmaps = 6'd1; arv_tile = 4'd0; arv_ofmaps = 6'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    step_ready = 1'b1;
    for (int s = 0; s < 4; s++) tick();
    check("rst_step5", obs(), pk(1'b1, 1'b1, 1'b0, tbl[4], 6'd9, 6'd3));
    rst_n = 1'b0;
    tick();
    check("rst_mid", obs(), 36'd0);
`ifdef CTRL_LOOP_SEQ_STALLCNT_EN
    check("rst_stallcnt", 36'(stall_cnt), 36'd0);
`endif
    rst_n = 1'b1;
    step_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick();
      check("rst_idle", obs(), 36'd0);
    end

    build_q(2, 1, 0, 1);
    run_layer("restart", 2, 1, 0, 1, 6'd9, 6'd3, 0, 1'b0, 1'b0);

    build_q(7, 1, 15, 1);
    run_layer("maxw", 7, 1, 15, 1, 6'd63, 6'd63, 0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
